// File: rtl/alu_pkg.sv
// Shared integer ALU definitions.
// Opcode encodings, widths and the ALU output bundle.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 5;

  typedef enum logic [OPW-1:0] {
    ALU_ADD     = 5'd0,
    ALU_SLL     = 5'd1,
    ALU_SLT     = 5'd2,
    ALU_SLTU    = 5'd3,
    ALU_XOR     = 5'd4,
    ALU_SRL     = 5'd5,
    ALU_OR      = 5'd6,
    ALU_AND     = 5'd7,
    ALU_SRA     = 5'd13,
    ALU_FORWARD = 5'd16
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            sign_bit;
    logic            sltu_bit;
  } alu_out_t;

endpackage

// File: rtl/alu_int.sv
// Combinational integer ALU.
// Result plus zero, sign and unsigned-less-than flags.
module alu_int
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  input  logic [OPW-1:0]  ALU_OP,
  output alu_out_t        RES
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] result;
  logic            slt;
  logic            sltu;

  assign shamt = OP2[4:0];
  assign slt   = $signed(OP1) < $signed(OP2);
  assign sltu  = OP1 < OP2;

  // opcode decode; unknown opcodes yield zero
  always_comb begin
    result = '0;
    case (ALU_OP)
      ALU_ADD:     result = OP1 + OP2;
      ALU_SLL:     result = OP1 << shamt;
      ALU_SLT:     result = {{(XLEN-1){1'b0}}, slt};
      ALU_SLTU:    result = {{(XLEN-1){1'b0}}, sltu};
      ALU_XOR:     result = OP1 ^ OP2;
      ALU_SRL:     result = OP1 >> shamt;
      ALU_OR:      result = OP1 | OP2;
      ALU_AND:     result = OP1 & OP2;
      ALU_SRA:     result = $unsigned($signed(OP1) >>> shamt);
      ALU_FORWARD: result = OP2;
      default:     result = '0;
    endcase
  end

  assign RES = {result, result == '0, result[XLEN-1], sltu};

endmodule

// File: rtl/alu_int_arbiter.sv
// Two-port arbiter in front of one shared alu_int.
// One registered result slot, routed back to its issuer.
module alu_int_arbiter
  import alu_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 8
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            REQ0_VALID,
  output logic            REQ0_READY,
  input  logic [XLEN-1:0] REQ0_OP1,
  input  logic [XLEN-1:0] REQ0_OP2,
  input  logic [OPW-1:0]  REQ0_ALU_OP,
  input  logic            REQ1_VALID,
  output logic            REQ1_READY,
  input  logic [XLEN-1:0] REQ1_OP1,
  input  logic [XLEN-1:0] REQ1_OP2,
  input  logic [OPW-1:0]  REQ1_ALU_OP,
  output logic            RSP0_VALID,
  input  logic            RSP0_READY,
  output logic [XLEN-1:0] RSP0_RESULT,
  output logic            RSP0_ZERO,
  output logic            RSP0_SIGN_BIT,
  output logic            RSP0_SLTU_BIT,
  output logic            RSP1_VALID,
  input  logic            RSP1_READY,
  output logic [XLEN-1:0] RSP1_RESULT,
  output logic            RSP1_ZERO,
  output logic            RSP1_SIGN_BIT,
  output logic            RSP1_SLTU_BIT
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic            out_valid;
  logic            owner;
  logic            rr_last;
  logic [7:0]      wait_cnt;
  alu_out_t        out_q;
  alu_out_t        alu_res;
  alu_out_t        rsp0_q;
  alu_out_t        rsp1_q;

  logic            drain;
  logic            can_accept;
  logic            pick1;
  logic [1:0]      grant;
  logic            accept;
  logic            sel;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [OPW-1:0]  alu_op;

  assign drain      = out_valid & (owner ? RSP1_READY : RSP0_READY);
  assign can_accept = ~out_valid | drain;

  // port 1 wins a tie when it is its turn (rr) or it has starved (fixed)
  assign pick1 = (FIXED_PRIO != 0) ? (wait_cnt == WAIT_MAX)
                                   : ~rr_last;

  // one-hot grant, only while the result slot can take a new op
  always_comb begin
    grant = 2'b00;
    if (can_accept) begin
      unique case (1'b1)
        REQ0_VALID & REQ1_VALID:  grant = pick1 ? 2'b10 : 2'b01;
        REQ0_VALID & ~REQ1_VALID: grant = 2'b01;
        REQ1_VALID & ~REQ0_VALID: grant = 2'b10;
        default:                  grant = 2'b00;
      endcase
    end
  end

  assign accept     = |grant;
  assign sel        = grant[1];
  assign REQ0_READY = grant[0];
  assign REQ1_READY = grant[1];

  assign op1    = sel ? REQ1_OP1    : REQ0_OP1;
  assign op2    = sel ? REQ1_OP2    : REQ0_OP2;
  assign alu_op = sel ? REQ1_ALU_OP : REQ0_ALU_OP;

  alu_int u_alu (
    .OP1    (op1),
    .OP2    (op2),
    .ALU_OP (alu_op),
    .RES    (alu_res)
  );

  // result slot: refill on accept, otherwise empty on drain
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid <= 1'b0;
      owner     <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      owner     <= sel;
      out_q     <= alu_res;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // last winner, so a tie goes to the other port next
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= sel;
    end
  end

  // cycles port 1 has been held off while valid
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt <= '0;
    end else if (FIXED_PRIO == 0) begin
      wait_cnt <= '0;
    end else if (REQ1_VALID & ~REQ1_READY) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign RSP0_VALID = out_valid & ~owner;
  assign RSP1_VALID = out_valid & owner;

  assign rsp0_q = RSP0_VALID ? out_q : '0;
  assign rsp1_q = RSP1_VALID ? out_q : '0;

  assign RSP0_RESULT   = rsp0_q.result;
  assign RSP0_ZERO     = rsp0_q.zero;
  assign RSP0_SIGN_BIT = rsp0_q.sign_bit;
  assign RSP0_SLTU_BIT = rsp0_q.sltu_bit;
  assign RSP1_RESULT   = rsp1_q.result;
  assign RSP1_ZERO     = rsp1_q.zero;
  assign RSP1_SIGN_BIT = rsp1_q.sign_bit;
  assign RSP1_SLTU_BIT = rsp1_q.sltu_bit;

endmodule

// File: tb/tb_alu_int_arbiter.sv
// Bench for alu_int_arbiter: round-robin and fixed-priority
// instances, scoreboard per port, arbitration reference model.
module tb_alu_int_arbiter;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        s;
    logic        u;
  } exp_t;

  logic        CLK;
  logic        RESET_N;
  logic        req_valid  [2][2];
  logic        req_ready  [2][2];
  logic [31:0] req_op1    [2][2];
  logic [31:0] req_op2    [2][2];
  logic [4:0]  req_op     [2][2];
  logic        rsp_valid  [2][2];
  logic        rsp_ready  [2][2];
  logic [31:0] rsp_result [2][2];
  logic        rsp_zero   [2][2];
  logic        rsp_sign   [2][2];
  logic        rsp_sltu   [2][2];

  exp_t expq [2][2][$];
  int   glog [2][$];

  int n_tests;
  int n_fail;

  bit m_occ  [2];
  int m_own  [2];
  int m_last [2];
  int m_wait [2];

  int ops [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 13, 16};

  alu_int_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(8)) dut_rr (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0_VALID(req_valid[0][0]), .REQ0_READY(req_ready[0][0]),
    .REQ0_OP1(req_op1[0][0]), .REQ0_OP2(req_op2[0][0]),
    .REQ0_ALU_OP(req_op[0][0]),
    .REQ1_VALID(req_valid[0][1]), .REQ1_READY(req_ready[0][1]),
    .REQ1_OP1(req_op1[0][1]), .REQ1_OP2(req_op2[0][1]),
    .REQ1_ALU_OP(req_op[0][1]),
    .RSP0_VALID(rsp_valid[0][0]), .RSP0_READY(rsp_ready[0][0]),
    .RSP0_RESULT(rsp_result[0][0]), .RSP0_ZERO(rsp_zero[0][0]),
    .RSP0_SIGN_BIT(rsp_sign[0][0]), .RSP0_SLTU_BIT(rsp_sltu[0][0]),
    .RSP1_VALID(rsp_valid[0][1]), .RSP1_READY(rsp_ready[0][1]),
    .RSP1_RESULT(rsp_result[0][1]), .RSP1_ZERO(rsp_zero[0][1]),
    .RSP1_SIGN_BIT(rsp_sign[0][1]), .RSP1_SLTU_BIT(rsp_sltu[0][1])
  );

  alu_int_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(3)) dut_fx (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0_VALID(req_valid[1][0]), .REQ0_READY(req_ready[1][0]),
    .REQ0_OP1(req_op1[1][0]), .REQ0_OP2(req_op2[1][0]),
    .REQ0_ALU_OP(req_op[1][0]),
    .REQ1_VALID(req_valid[1][1]), .REQ1_READY(req_ready[1][1]),
    .REQ1_OP1(req_op1[1][1]), .REQ1_OP2(req_op2[1][1]),
    .REQ1_ALU_OP(req_op[1][1]),
    .RSP0_VALID(rsp_valid[1][0]), .RSP0_READY(rsp_ready[1][0]),
    .RSP0_RESULT(rsp_result[1][0]), .RSP0_ZERO(rsp_zero[1][0]),
    .RSP0_SIGN_BIT(rsp_sign[1][0]), .RSP0_SLTU_BIT(rsp_sltu[1][0]),
    .RSP1_VALID(rsp_valid[1][1]), .RSP1_READY(rsp_ready[1][1]),
    .RSP1_RESULT(rsp_result[1][1]), .RSP1_ZERO(rsp_zero[1][1]),
    .RSP1_SIGN_BIT(rsp_sign[1][1]), .RSP1_SLTU_BIT(rsp_sltu[1][1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int d,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got %h expected %h @%0t",
               name, d, got, exp, $time);
    end
  endtask

  // reference ALU from the opcode definitions
  function automatic exp_t ref_alu(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [4:0] op);
    logic [31:0] r;
    logic [31:0] p2;
    int sh;
    sh = int'(b[4:0]);
    p2 = 32'd1 << sh;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a * p2;
      5'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd3:  r = (a < b) ? 32'd1 : 32'd0;
      5'd4:  r = a ^ b;
      5'd5:  r = a / p2;
      5'd6:  r = a | b;
      5'd7:  r = a & b;
      5'd13: r = (a / p2) | (a[31] ? ~(32'hFFFF_FFFF / p2) : 32'd0);
      5'd16: r = b;
      default: r = 32'd0;
    endcase
    return {r, r == 32'd0, r[31], a < b};
  endfunction

  task automatic issue(input int d, input int p, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid[d][p] = 1'b1;
    req_op[d][p]    = op;
    req_op1[d][p]   = a;
    req_op2[d][p]   = b;
    expq[d][p].push_back(ref_alu(a, b, op));
  endtask

  task automatic issue_rand(input int d, input int p);
    logic [31:0] a;
    logic [31:0] b;
    int k;
    k = int'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    if (k == 1) begin
      a = 32'($urandom_range(0, 20));
      b = 32'($urandom_range(0, 20));
    end else if (k == 2) begin
      b = a;
    end
    issue(d, p, 5'(ops[$urandom_range(0, 9)]), a, b);
  endtask

  // mode 0: finish then idle, 1: ADD/XOR stream, 2: random, 3: idle, no drain
  task automatic cycle(input int mode);
    bit fired [2][2];
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        fired[d][p] = req_valid[d][p] && req_ready[d][p];
      end
      if (mode == 1) begin
        if (fired[d][0]) glog[d].push_back(0);
        else if (fired[d][1]) glog[d].push_back(1);
      end
    end
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[d][p] || fired[d][p]) begin
          if (mode == 1) begin
            if (p == 0) issue(d, p, 5'd0, 32'd1, 32'd1);
            else issue(d, p, 5'd4, 32'hAAAA, 32'h5555);
          end else if (mode == 2 && $urandom_range(0, 3) != 0) begin
            issue_rand(d, p);
          end else begin
            req_valid[d][p] = 1'b0;
          end
        end
        if (mode == 2) rsp_ready[d][p] = ($urandom_range(0, 2) != 0);
        else rsp_ready[d][p] = (mode != 3);
      end
    end
  endtask

  // monitor: arbitration model plus scoreboard pops
  always @(negedge CLK) begin
    if (!RESET_N) begin
      for (int d = 0; d < 2; d++) begin
        m_occ[d]  = 1'b0;
        m_own[d]  = 0;
        m_last[d] = 1;
        m_wait[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit   can;
        bit   v0;
        bit   v1;
        int   w;
        logic [1:0] er;
        logic [1:0] ev;
        exp_t got;
        exp_t ex;
        v0  = req_valid[d][0];
        v1  = req_valid[d][1];
        can = !m_occ[d] || rsp_ready[d][m_own[d]];
        w   = -1;
        if (can) begin
          if (v0 && !v1) w = 0;
          else if (v1 && !v0) w = 1;
          else if (v0 && v1) begin
            if (d == 0) w = (m_last[d] == 0) ? 1 : 0;
            else w = (m_wait[d] >= 3) ? 1 : 0;
          end
        end
        er = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        ev = !m_occ[d] ? 2'b00 : (m_own[d] == 1) ? 2'b10 : 2'b01;
        check("req_ready", d, 64'({req_ready[d][1], req_ready[d][0]}),
              64'(er));
        check("rsp_valid", d, 64'({rsp_valid[d][1], rsp_valid[d][0]}),
              64'(ev));
        for (int p = 0; p < 2; p++) begin
          got = {rsp_result[d][p], rsp_zero[d][p],
                 rsp_sign[d][p], rsp_sltu[d][p]};
          if (rsp_valid[d][p] && rsp_ready[d][p]) begin
            if (expq[d][p].size() == 0) begin
              check($sformatf("rsp%0d_unexpected", p), d, 64'd1, 64'd0);
            end else begin
              ex = expq[d][p].pop_front();
              check($sformatf("rsp%0d_data", p), d, 64'(got), 64'(ex));
            end
          end
          if (rsp_valid[d][1-p]) begin
            check($sformatf("rsp%0d_idle_payload", p), d,
                  64'(got), 64'd0);
          end
        end
        if (w >= 0) begin
          m_occ[d]  = 1'b1;
          m_own[d]  = w;
          m_last[d] = w;
        end else if (m_occ[d] && rsp_ready[d][m_own[d]]) begin
          m_occ[d] = 1'b0;
        end
        if (v1 && w != 1) m_wait[d] = (m_wait[d] >= 3) ? 3 : m_wait[d] + 1;
        else m_wait[d] = 0;
      end
    end
  end

  initial begin
    int guard;
    int eg;
    n_tests = 0;
    n_fail  = 0;
    RESET_N = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req_valid[d][p] = 1'b0;
        req_op1[d][p]   = '0;
        req_op2[d][p]   = '0;
        req_op[d][p]    = '0;
        rsp_ready[d][p] = 1'b1;
      end
    end
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("reset_rsp%0d", p), d,
              64'({rsp_valid[d][p], rsp_result[d][p], rsp_zero[d][p],
                   rsp_sign[d][p], rsp_sltu[d][p]}), 64'd0);
      end
    end
    RESET_N = 1'b1;

    guard = 0;
    while ((glog[0].size() < 8 || glog[1].size() < 8) && guard < 40) begin
      cycle(1);
      guard++;
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        eg = (d == 0) ? (i % 2) : ((i % 4 == 3) ? 1 : 0);
        check($sformatf("grant_seq%0d", i), d,
              64'((i < glog[d].size()) ? glog[d][i] : 9), 64'(eg));
      end
    end
    repeat (6) cycle(0);

    repeat (3000) cycle(2);
    repeat (20) cycle(0);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("drained%0d", p), d,
              64'(expq[d][p].size()), 64'd0);
      end
    end

    for (int d = 0; d < 2; d++) begin
      issue(d, 1, 5'd4, 32'h1234, 32'h1234);
      for (int p = 0; p < 2; p++) rsp_ready[d][p] = 1'b0;
    end
    repeat (3) cycle(3);
    for (int d = 0; d < 2; d++) begin
      check("pre_reset_rsp1", d, 64'(rsp_valid[d][1]), 64'd1);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_async", d,
            64'({rsp_valid[d][1], rsp_valid[d][0]}), 64'd0);
      for (int p = 0; p < 2; p++) begin
        req_valid[d][p] = 1'b0;
        rsp_ready[d][p] = 1'b1;
        expq[d][p].delete();
      end
      glog[d].delete();
    end
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    repeat (2) cycle(3);
    repeat (2) cycle(1);
    for (int d = 0; d < 2; d++) begin
      check("first_grant_after_reset", d,
            64'((glog[d].size() > 0) ? glog[d][0] : 9), 64'd0);
    end
    repeat (10) cycle(0);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("final_drained%0d", p), d,
              64'(expq[d][p].size()), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
